// File: rtl/ref_freq_meter_pkg.sv
// Shared definitions for the reference frequency meter: lock-state encoding and
// the derived measurement widths used by the meter and its 250 MHz-domain consumers.
package ref_freq_meter_pkg;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_QUALIFY  = 2'd1,
      ST_LOCKED   = 2'd2
   } meter_state_t;

   // Edge counter width: headroom for twice the nominal count plus saturation.
   function automatic int count_width(input int gate_w, input int div_log2);
      return gate_w - div_log2 + 2;
   endfunction

   // Both polarities of int_div_in are counted, so a gate sees 2^(gate_w-div_log2) edges.
   function automatic int nominal_count(input int gate_w, input int div_log2);
      return 1 << (gate_w - div_log2);
   endfunction

endpackage

// File: rtl/ref_freq_meter_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases after STAGES clean edges
// of the external reference clock.
module ref_freq_meter_rst_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_10mhz_ext_bufg,
   input  logic rst_250mhz_int,
   output logic rst_sync_int
);

   logic [STAGES-1:0] sync_reg;

   always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_250mhz_int) begin
      if (rst_250mhz_int) begin
         sync_reg <= '1;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], 1'b0};
      end
   end

   assign rst_sync_int = sync_reg[STAGES-1];

endmodule

// File: rtl/ref_freq_meter.sv
// Gated frequency meter in the external 10 MHz domain: counts int-ref edges per gate,
// reports the saturated signed error and qualifies lock with hysteresis.
module ref_freq_meter
   import ref_freq_meter_pkg::*;
#(
   parameter int GATE_W   = 16,
   parameter int DIV_LOG2 = 3,
   parameter int ERR_W    = 16,
   parameter int TOL_LOCK = 2,
   parameter int TOL_LOSS = 4,
   parameter int QUAL_CNT = 16,
   parameter int LOSS_CNT = 4,
   localparam int CW      = count_width(GATE_W, DIV_LOG2)
) (
   input  logic             clk_10mhz_ext_bufg,
   input  logic             rst_250mhz_int,
   input  logic             int_div_in,
   output logic [CW-1:0]    meas_count,
   output logic [ERR_W-1:0] meas_err,
   output logic             meas_sat,
   output logic             meas_valid,
   output logic             meas_toggle,
   output logic [1:0]       state,
   output logic             locked
);

   localparam int NOMINAL = nominal_count(GATE_W, DIV_LOG2);
   localparam int ERR_MAX = (1 << (ERR_W - 1)) - 1;
   localparam int ERR_MIN = -(1 << (ERR_W - 1));
   localparam int QW      = $clog2(QUAL_CNT + 1);
   localparam int MW      = $clog2(LOSS_CNT + 1);

   logic rst_int;

   ref_freq_meter_rst_sync #(
      .STAGES(2)
   ) u_rst_sync (
      .clk_10mhz_ext_bufg(clk_10mhz_ext_bufg),
      .rst_250mhz_int    (rst_250mhz_int),
      .rst_sync_int      (rst_int)
   );

   logic [2:0]        sync_reg;
   logic              edge_det;
   logic [GATE_W-1:0] gate_cnt_reg;
   logic [CW-1:0]     edge_cnt_reg;
   logic              sat_reg;
   logic              first_done_reg;
   logic [CW-1:0]     meas_count_reg;
   logic [ERR_W-1:0]  meas_err_reg;
   logic              meas_sat_reg;
   logic              meas_valid_reg;
   logic              meas_toggle_reg;
   logic              gate_end;
   logic [CW-1:0]     cnt_now;
   logic              sat_now;
   logic [ERR_W-1:0]  err_now;
   int                err_int;

   always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_int) begin
      if (rst_int) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[1:0], int_div_in};
      end
   end

   assign edge_det = sync_reg[1] ^ sync_reg[2];
   assign gate_end = &gate_cnt_reg;

   always_comb begin
      cnt_now = edge_cnt_reg;
      sat_now = sat_reg;
      if (edge_det) begin
         if (&edge_cnt_reg) begin
            sat_now = 1'b1;
         end else begin
            cnt_now = edge_cnt_reg + CW'(1);
         end
      end
      err_int = int'(cnt_now) - NOMINAL;
      if (err_int > ERR_MAX) begin
         err_now = ERR_W'(ERR_MAX);
      end else if (err_int < ERR_MIN) begin
         err_now = ERR_W'(ERR_MIN);
      end else begin
         err_now = ERR_W'(err_int);
      end
   end

   // The gate that started during reset release also spans synchroniser warm-up,
   // so its result is dropped.
   always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_int) begin
      if (rst_int) begin
         gate_cnt_reg    <= '0;
         edge_cnt_reg    <= '0;
         sat_reg         <= 1'b0;
         first_done_reg  <= 1'b0;
         meas_count_reg  <= '0;
         meas_err_reg    <= '0;
         meas_sat_reg    <= 1'b0;
         meas_valid_reg  <= 1'b0;
         meas_toggle_reg <= 1'b0;
      end else begin
         gate_cnt_reg   <= gate_cnt_reg + GATE_W'(1);
         meas_valid_reg <= 1'b0;
         if (gate_end) begin
            edge_cnt_reg   <= '0;
            sat_reg        <= 1'b0;
            first_done_reg <= 1'b1;
            if (first_done_reg) begin
               meas_count_reg  <= cnt_now;
               meas_err_reg    <= err_now;
               meas_sat_reg    <= sat_now;
               meas_valid_reg  <= 1'b1;
               meas_toggle_reg <= ~meas_toggle_reg;
            end
         end else begin
            edge_cnt_reg <= cnt_now;
            sat_reg      <= sat_now;
         end
      end
   end

   meter_state_t  state_reg, state_next;
   logic [QW-1:0] qual_reg, qual_next;
   logic [MW-1:0] miss_reg, miss_next;
   int            err_abs;
   logic          gate_good;
   logic          gate_bad;

   // Hysteresis: a gate can be neither good nor bad.
   always_comb begin
      err_abs = int'($signed(meas_err_reg));
      if (err_abs < 0) begin
         err_abs = -err_abs;
      end
      gate_good = !meas_sat_reg && (err_abs <= TOL_LOCK);
      gate_bad  = meas_sat_reg || (err_abs > TOL_LOSS);
   end

   always_comb begin
      state_next = state_reg;
      qual_next  = qual_reg;
      miss_next  = miss_reg;
      case (state_reg)
         ST_UNLOCKED: begin
            if (meas_valid_reg && gate_good) begin
               state_next = ST_QUALIFY;
               qual_next  = QW'(1);
            end
         end
         ST_QUALIFY: begin
            if (meas_valid_reg) begin
               if (gate_good) begin
                  qual_next = qual_reg + QW'(1);
                  if (qual_reg + QW'(1) == QW'(QUAL_CNT)) begin
                     state_next = ST_LOCKED;
                     miss_next  = '0;
                  end
               end else begin
                  state_next = ST_UNLOCKED;
                  qual_next  = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (meas_valid_reg) begin
               if (gate_bad) begin
                  miss_next = miss_reg + MW'(1);
                  if (miss_reg + MW'(1) == MW'(LOSS_CNT)) begin
                     state_next = ST_UNLOCKED;
                     qual_next  = '0;
                     miss_next  = '0;
                  end
               end else begin
                  miss_next = '0;
               end
            end
         end
         default: begin
            state_next = ST_UNLOCKED;
            qual_next  = '0;
            miss_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_int) begin
      if (rst_int) begin
         state_reg <= ST_UNLOCKED;
         qual_reg  <= '0;
         miss_reg  <= '0;
      end else begin
         state_reg <= state_next;
         qual_reg  <= qual_next;
         miss_reg  <= miss_next;
      end
   end

   assign meas_count  = meas_count_reg;
   assign meas_err    = meas_err_reg;
   assign meas_sat    = meas_sat_reg;
   assign meas_valid  = meas_valid_reg;
   assign meas_toggle = meas_toggle_reg;
   assign state       = state_reg;
   assign locked      = (state_reg == ST_LOCKED);

endmodule

// File: tb/tb_ref_freq_meter.sv
// Directed bench for ref_freq_meter with a shortened gate (256 cycles, nominal 32 edges,
// 6-bit error) so lock acquisition, hysteresis, saturation and reset fit in a short run.
module tb_ref_freq_meter;

   localparam int GATE_W   = 8;
   localparam int DIV_LOG2 = 3;
   localparam int ERR_W    = 6;
   localparam int CW       = GATE_W - DIV_LOG2 + 2;

   logic              clk_10mhz_ext_bufg = 1'b0;
   logic              rst_250mhz_int     = 1'b1;
   logic              int_div_in         = 1'b0;
   logic [CW-1:0]     meas_count;
   logic [ERR_W-1:0]  meas_err;
   logic              meas_sat;
   logic              meas_valid;
   logic              meas_toggle;
   logic [1:0]        state;
   logic              locked;

   ref_freq_meter #(
      .GATE_W  (GATE_W),
      .DIV_LOG2(DIV_LOG2),
      .ERR_W   (ERR_W),
      .TOL_LOCK(2),
      .TOL_LOSS(4),
      .QUAL_CNT(16),
      .LOSS_CNT(4)
   ) dut (
      .clk_10mhz_ext_bufg(clk_10mhz_ext_bufg),
      .rst_250mhz_int    (rst_250mhz_int),
      .int_div_in        (int_div_in),
      .meas_count        (meas_count),
      .meas_err          (meas_err),
      .meas_sat          (meas_sat),
      .meas_valid        (meas_valid),
      .meas_toggle       (meas_toggle),
      .state             (state),
      .locked            (locked)
   );

   always #5 clk_10mhz_ext_bufg = ~clk_10mhz_ext_bufg;

   // FREE: exact period-16 square wave; ALIGN: k toggles every 4 cycles from gate start;
   // HOLD: no toggles; FAST: toggle every cycle.
   typedef enum int {M_FREE, M_ALIGN, M_HOLD, M_FAST} mode_t;

   typedef struct {
      mode_t mode;
      int    k;
      bit    chk;
      int    cnt;
      int    err;
      bit    sat;
      int    st;
   } vec_t;

   vec_t  tbl[$];
   vec_t  prev;
   mode_t mode_cur  = M_FREE;
   mode_t mode_next = M_FREE;
   int    k_cur     = 32;
   int    k_next    = 32;
   int    ph        = 0;
   int    tcnt      = 0;
   int    n_checks  = 0;
   int    n_fail    = 0;
   int    gate_no   = 0;
   int    cyc       = 0;
   bit    exp_tog   = 1'b0;

   initial begin
      forever begin
         @(posedge clk_10mhz_ext_bufg);
         #1;
         if (meas_valid) begin
            ph       = 0;
            k_cur    = k_next;
            mode_cur = mode_next;
         end else begin
            ph++;
         end
         case (mode_cur)
            M_FREE:  if (tcnt % 8 == 0) int_div_in = ~int_div_in;
            M_ALIGN: if ((ph % 4 == 0) && (ph / 4 < k_cur)) int_div_in = ~int_div_in;
            M_FAST:  int_div_in = ~int_div_in;
            default: ;
         endcase
         tcnt++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_valid(input string name, input int limit, output int cycles);
      cycles = 0;
      do begin
         @(posedge clk_10mhz_ext_bufg);
         #1;
         cycles++;
      end while (!meas_valid && cycles < limit);
      if (!meas_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: no meas_valid within %0d cycles", name, limit);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_count"}, int'(meas_count), 0);
      check({tag, "_err"}, int'(meas_err), 0);
      check({tag, "_sat"}, int'(meas_sat), 0);
      check({tag, "_valid"}, int'(meas_valid), 0);
      check({tag, "_toggle"}, int'(meas_toggle), 0);
      check({tag, "_state"}, int'(state), 0);
      check({tag, "_locked"}, int'(locked), 0);
   endtask

   // Called in the meas_valid cycle; state is checked one cycle later.
   task automatic check_meas(input vec_t v, input string tag);
      gate_no++;
      exp_tog = ~exp_tog;
      $display("gate %0d %s: count=%0d err=%0d sat=%0d toggle=%0d", gate_no, tag,
               meas_count, $signed(meas_err), meas_sat, meas_toggle);
      if (v.chk) begin
         check({tag, "_count"}, int'(meas_count), v.cnt);
         check({tag, "_err"}, int'($signed(meas_err)), v.err);
      end
      check({tag, "_sat"}, int'(meas_sat), int'(v.sat));
      check({tag, "_toggle"}, int'(meas_toggle), int'(exp_tog));
      @(posedge clk_10mhz_ext_bufg);
      #1;
      check({tag, "_strobe"}, int'(meas_valid), 0);
      check({tag, "_state"}, int'(state), v.st);
      check({tag, "_locked"}, int'(locked), int'(v.st == 2));
   endtask

   function automatic vec_t mk(mode_t m, int k, bit chk, int cnt, int err, bit sat, int st);
      vec_t v;
      v.mode = m; v.k = k; v.chk = chk; v.cnt = cnt; v.err = err; v.sat = sat; v.st = st;
      return v;
   endfunction

   task automatic add(input mode_t m, input int k, input bit chk, input int cnt,
                      input int err, input bit sat, input int st, input int reps);
      for (int r = 0; r < reps; r++) tbl.push_back(mk(m, k, chk, cnt, err, sat, st));
   endtask

   initial begin
      repeat (3) @(posedge clk_10mhz_ext_bufg);
      #1;
      check_zero("reset");
      rst_250mhz_int = 1'b0;

      // Gate 1 is discarded, so the first strobe ends the second gate (2*256 + 2 cycles).
      wait_valid("first_valid", 700, cyc);
      $display("first meas_valid %0d cycles after reset release", cyc);
      check("first_valid_latency", int'(cyc >= 508 && cyc <= 520), 1);
      for (int r = 1; r <= 16; r++) begin
         if (r > 1) wait_valid("acquire_valid", 300, cyc);
         check_meas(mk(M_FREE, 32, 1'b1, 32, 0, 1'b0, (r == 16) ? 2 : 1), "acquire");
      end

      add(M_ALIGN, 32, 1'b0, 0, 0, 1'b0, 2, 1);
      add(M_ALIGN, 35, 1'b1, 35, 3, 1'b0, 2, 10);
      add(M_ALIGN, 37, 1'b1, 37, 5, 1'b0, 2, 3);
      add(M_ALIGN, 32, 1'b1, 32, 0, 1'b0, 2, 1);
      add(M_ALIGN, 37, 1'b1, 37, 5, 1'b0, 2, 3);
      add(M_ALIGN, 32, 1'b1, 32, 0, 1'b0, 2, 1);
      add(M_ALIGN, 37, 1'b1, 37, 5, 1'b0, 2, 3);
      add(M_ALIGN, 37, 1'b1, 37, 5, 1'b0, 0, 1);
      add(M_ALIGN, 40, 1'b1, 40, 8, 1'b0, 0, 3);
      add(M_ALIGN, 35, 1'b1, 35, 3, 1'b0, 0, 1);
      add(M_ALIGN, 34, 1'b1, 34, 2, 1'b0, 1, 1);
      add(M_ALIGN, 35, 1'b1, 35, 3, 1'b0, 0, 1);
      add(M_ALIGN, 30, 1'b1, 30, -2, 1'b0, 1, 1);
      add(M_ALIGN, 29, 1'b1, 29, -3, 1'b0, 0, 1);
      for (int r = 1; r <= 16; r++) begin
         if (r % 2 == 1) add(M_ALIGN, 31, 1'b1, 31, -1, 1'b0, (r == 16) ? 2 : 1, 1);
         else            add(M_ALIGN, 33, 1'b1, 33, 1, 1'b0, (r == 16) ? 2 : 1, 1);
      end
      add(M_ALIGN, 36, 1'b1, 36, 4, 1'b0, 2, 5);
      add(M_ALIGN, 28, 1'b1, 28, -4, 1'b0, 2, 3);
      add(M_HOLD, 0, 1'b1, 0, -32, 1'b0, 2, 3);
      add(M_HOLD, 0, 1'b1, 0, -32, 1'b0, 0, 1);
      add(M_FAST, 0, 1'b1, 127, 31, 1'b1, 0, 3);
      // Two FAST toggles are still in the synchroniser when this gate opens.
      add(M_ALIGN, 32, 1'b1, 34, 2, 1'b0, 1, 1);
      add(M_ALIGN, 32, 1'b1, 32, 0, 1'b0, 1, 1);

      prev = mk(M_FREE, 32, 1'b1, 32, 0, 1'b0, 2);
      for (int i = 0; i < tbl.size(); i++) begin
         mode_next = tbl[i].mode;
         k_next    = tbl[i].k;
         wait_valid("table_valid", 300, cyc);
         check_meas(prev, "table");
         prev = tbl[i];
      end
      wait_valid("table_valid", 300, cyc);
      check_meas(prev, "table");

      // Reset in the middle of a gate while qualifying.
      repeat (100) @(posedge clk_10mhz_ext_bufg);
      #3;
      rst_250mhz_int = 1'b1;
      #1;
      check_zero("midreset");
      repeat (3) @(posedge clk_10mhz_ext_bufg);
      mode_cur  = M_FREE;
      mode_next = M_FREE;
      exp_tog   = 1'b0;
      #1;
      rst_250mhz_int = 1'b0;
      wait_valid("rerelease_valid", 700, cyc);
      $display("meas_valid %0d cycles after mid-gate reset release", cyc);
      check("rerelease_latency", int'(cyc >= 508 && cyc <= 520), 1);
      check_meas(mk(M_FREE, 32, 1'b1, 32, 0, 1'b0, 1), "rerelease");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
